// File: rtl/bayer_dither_stream_if.sv
// Stream bundle for the Bayer dither block: grey pixels in, dithered
// pixels out with their raster position and line/frame markers.
// "slave" is the dither block's view; "master" is the surrounding
// pipeline (upstream source plus downstream sink).
interface bayer_dither_stream_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 1
);
    logic              s_valid;
    logic              s_ready;
    logic [DATA_W-1:0] s_data;
    logic              s_sof;
    logic              m_valid;
    logic              m_ready;
    logic [OUT_W-1:0]  m_data;
    logic [8:0]        m_x;
    logic [8:0]        m_y;
    logic              m_eol;
    logic              m_eof;

    modport slave (
        input  s_valid, s_data, s_sof, m_ready,
        output s_ready, m_valid, m_data, m_x, m_y, m_eol, m_eof
    );

    modport master (
        output s_valid, s_data, s_sof, m_ready,
        input  s_ready, m_valid, m_data, m_x, m_y, m_eol, m_eof
    );
endinterface

// File: rtl/bayer_dither_stream.sv
// Streaming ordered (Bayer) dither from DATA_W-bit grey to OUT_W bits.
// Keeps its own raster counters, latches the matrix size at each (0,0)
// pixel and runs a two-stage pipeline with full backpressure.
// Optional feature: define DITHER_TEMPORAL_EN to shift the threshold
// pattern by half a tile each frame using a 2-bit frame counter.
module bayer_dither_stream #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 1,
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] cfg_mode,
    bayer_dither_stream_if.slave bus
);
    localparam logic [OUT_W-1:0] LMAX   = '1;
    localparam logic [8:0]       X_LAST = 9'(IMG_W - 1);
    localparam logic [8:0]       Y_LAST = 9'(IMG_H - 1);

    // Scale by L = 2^OUT_W-1; returns {integer part, top 6 fraction bits}.
    function automatic logic [OUT_W+5:0] quantise(input logic [DATA_W-1:0] d);
        logic [DATA_W+OUT_W-1:0] p;
        p = {{OUT_W{1'b0}}, d} * {{DATA_W{1'b0}}, LMAX};
        return {p[DATA_W+OUT_W-1:DATA_W], p[DATA_W-1 -: 6]};
    endfunction

    // Conditional increment clamped to the largest output code.
    function automatic logic [OUT_W-1:0] sat_inc(input logic [OUT_W-1:0] qv, input logic up);
        logic [OUT_W:0] s;
        s = {1'b0, qv} + {{OUT_W{1'b0}}, up};
        return (s > {1'b0, LMAX}) ? LMAX : s[OUT_W-1:0];
    endfunction

    // Bayer threshold on a 6-bit scale: interleave (x^y, y) bits, then
    // bit-reverse; reversing over 6 bits already applies the << (6-2k).
    function automatic logic [5:0] thresh6(input logic [2:0] fx, input logic [2:0] fy,
                                           input logic [1:0] fk);
        logic [5:0] v;
        logic [5:0] t;
        v = '0;
        for (int b = 0; b < 3; b++) begin
            if (b < int'(fk)) begin
                v[2*b]   = fx[b] ^ fy[b];
                v[2*b+1] = fy[b];
            end
        end
        for (int i = 0; i < 6; i++) t[i] = v[5-i];
        return t;
    endfunction

    logic             en, xfer, first_px;
    logic [8:0]       x_q, y_q, px, py, nx, ny;
    logic [1:0]       mode_q, mode_eff;
    logic [2:0]       xi, yi;
    logic [5:0]       t6_c, fi_c;
    logic [OUT_W-1:0] q_c;

    logic             vld_p1;
    logic [8:0]       x_p1, y_p1;
    logic [5:0]       t6_p1, fi_p1;
    logic [OUT_W-1:0] q_p1;

    assign en          = !bus.m_valid || bus.m_ready;
    assign bus.s_ready = en;
    assign xfer        = bus.s_valid && en;

    // Pixel position (s_sof resyncs to the origin) and next raster position.
    always_comb begin
        px       = bus.s_sof ? 9'd0 : x_q;
        py       = bus.s_sof ? 9'd0 : y_q;
        first_px = (px == 9'd0) && (py == 9'd0);
        mode_eff = first_px ? cfg_mode : mode_q;
        if (px == X_LAST) begin
            nx = 9'd0;
            ny = (py == Y_LAST) ? 9'd0 : py + 9'd1;
        end else begin
            nx = px + 9'd1;
            ny = py;
        end
    end

`ifdef DITHER_TEMPORAL_EN
    logic [1:0] fc_q, fc_eff;
    logic [2:0] half;
    logic       eof_p1;

    // End-of-frame pixels still in flight will bump the counter before the
    // pixel now entering reaches the output, so count them in advance.
    assign eof_p1 = vld_p1 && (x_p1 == X_LAST) && (y_p1 == Y_LAST);
    assign fc_eff = fc_q + {1'b0, eof_p1} + {1'b0, bus.m_valid && bus.m_eof};

    // Frame counter advances when the last pixel of a frame leaves.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            fc_q <= 2'd0;
        else if (bus.m_valid && bus.m_ready && bus.m_eof)
            fc_q <= fc_q + 2'd1;
    end

    // Matrix index offset by N/2 along x and/or y depending on the frame.
    always_comb begin
        case (mode_eff)
            2'd1:    half = 3'd1;
            2'd2:    half = 3'd2;
            2'd3:    half = 3'd4;
            default: half = 3'd0;
        endcase
        xi = px[2:0] + (fc_eff[0] ? half : 3'd0);
        yi = py[2:0] + (fc_eff[1] ? half : 3'd0);
    end
`else
    // Pattern is fixed to the raster position.
    always_comb begin
        xi = px[2:0];
        yi = py[2:0];
    end
`endif

    // Threshold and quantiser inputs; truncation and full-scale pixels get a
    // threshold no fraction can exceed so stage 2 never increments them.
    always_comb begin
        q_c  = '0;
        fi_c = 6'd0;
        t6_c = 6'h3f;
        if (mode_eff == 2'd0) begin
            q_c = bus.s_data[DATA_W-1 -: OUT_W];
        end else if (&bus.s_data) begin
            q_c = LMAX;
        end else begin
            {q_c, fi_c} = quantise(bus.s_data);
            t6_c        = thresh6(xi, yi, mode_eff);
        end
    end

    // Raster counters, latched matrix size and stage-1 valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_q    <= 9'd0;
            y_q    <= 9'd0;
            mode_q <= 2'd0;
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= xfer;
            if (xfer) begin
                x_q <= nx;
                y_q <= ny;
                if (first_px) mode_q <= cfg_mode;
            end
        end
    end

    // ---- stage 1: position, threshold, integer level and fraction ----
    always_ff @(posedge clk) begin
        if (xfer) begin
            x_p1  <= px;
            y_p1  <= py;
            t6_p1 <= t6_c;
            q_p1  <= q_c;
            fi_p1 <= fi_c;
        end
    end

    // ---- stage 2: compare, round up, emit with raster markers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.m_valid <= 1'b0;
            bus.m_data  <= '0;
            bus.m_x     <= 9'd0;
            bus.m_y     <= 9'd0;
            bus.m_eol   <= 1'b0;
            bus.m_eof   <= 1'b0;
        end else if (en) begin
            bus.m_valid <= vld_p1;
            if (vld_p1) begin
                bus.m_data <= sat_inc(q_p1, fi_p1 > t6_p1);
                bus.m_x    <= x_p1;
                bus.m_y    <= y_p1;
                bus.m_eol  <= (x_p1 == X_LAST);
                bus.m_eof  <= (x_p1 == X_LAST) && (y_p1 == Y_LAST);
            end
        end
    end
endmodule

// File: tb/tb_bayer_dither_stream.sv
// Self-checking bench for bayer_dither_stream on an 8x8 image.
module tb_bayer_dither_stream;
    localparam int DW   = 8;
    localparam int OW   = 1;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] cfg_mode = 2'd0;
    bit         rdy_rand = 1'b0;
    bit         cap_row0 = 1'b0;

    bayer_dither_stream_if #(.DATA_W(DW), .OUT_W(OW)) bus ();

    bayer_dither_stream #(.DATA_W(DW), .OUT_W(OW), .IMG_W(W), .IMG_H(H)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_mode (cfg_mode),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW-1:0] d;
        int            x;
        int            y;
        logic          eol;
        logic          eof;
    } exp_t;

    exp_t q_exp[$];
    int   n_cmp = 0, n_bad = 0;
    int   n_ones = 0, n_eol = 0, n_eof = 0;
    int   row0[W];
    int   bm[4][8][8];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
        n_cmp++;
        assert (obs === req) else begin
            n_bad++;
            $error("FAIL %s: got %0d, want %0d", tag, obs, req);
        end
    endtask

    // Classic recursive Bayer construction: M2n = [4M, 4M+2; 4M+3, 4M+1].
    function automatic void build_bayer();
        int addq[2][2] = '{'{0, 2}, '{3, 1}};
        bm[0][0][0] = 0;
        for (int k = 1; k < 4; k++) begin
            int n = 1 << (k - 1);
            for (int y = 0; y < 2 * n; y++)
                for (int x = 0; x < 2 * n; x++)
                    bm[k][y][x] = 4 * bm[k-1][y % n][x % n] + addq[y / n][x / n];
        end
    endfunction

    function automatic int ref_out(int s, int x, int y, int k, int fc);
        int lv = (1 << OW) - 1;
        int n  = 1 << k;
        int xi, yi, t6, prod, q, fi, o;
        if (k == 0) return s >> (DW - OW);
        if (s == (1 << DW) - 1) return lv;
        xi   = (x + (fc % 2) * (n / 2)) % n;
        yi   = (y + (fc / 2) * (n / 2)) % n;
        t6   = bm[k][yi][xi] * (1 << (6 - 2 * k));
        prod = s * lv;
        q    = prod >> DW;
        fi   = (prod % (1 << DW)) >> (DW - 6);
        o    = q + ((fi > t6) ? 1 : 0);
        return (o > lv) ? lv : o;
    endfunction

    function automatic logic [31:0] pack_out();
        return 32'({bus.m_data, bus.m_x, bus.m_y, bus.m_eol, bus.m_eof});
    endfunction

    // Downstream ready: always 1, or a fair coin each cycle.
    initial begin
        bus.m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            bus.m_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    // Reference model and scoreboard, sampled on the falling edge.
    initial begin
        int          mx = 0, my = 0, mfc = 0, px, py;
        logic [1:0]  mmode = 2'd0;
        bit          stall_prev = 1'b0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                q_exp.delete();
                mx = 0; my = 0; mfc = 0; mmode = 2'd0; stall_prev = 1'b0;
            end else begin
                if (stall_prev) chk("hold_during_stall", pack_out(), held);
                if (bus.m_valid && bus.m_ready) begin
                    chk("output_expected", 32'(q_exp.size() > 0), 32'd1);
                    if (q_exp.size() > 0) begin
                        e = q_exp.pop_front();
                        chk("m_data", 32'(bus.m_data), 32'(e.d));
                        chk("m_x", 32'(bus.m_x), 32'(e.x));
                        chk("m_y", 32'(bus.m_y), 32'(e.y));
                        chk("m_eol", 32'(bus.m_eol), 32'(e.eol));
                        chk("m_eof", 32'(bus.m_eof), 32'(e.eof));
                        n_ones += int'(bus.m_data != '0);
                        n_eol  += int'(bus.m_eol);
                        n_eof  += int'(bus.m_eof);
                        if (cap_row0 && e.y == 0) row0[e.x] = int'(bus.m_data);
                    end
                end
                stall_prev = bus.m_valid && !bus.m_ready;
                held       = pack_out();
                if (bus.s_valid && bus.s_ready) begin
                    px = bus.s_sof ? 0 : mx;
                    py = bus.s_sof ? 0 : my;
                    if (px == 0 && py == 0) mmode = cfg_mode;
                    e.d   = OW'(ref_out(int'(bus.s_data), px, py, int'(mmode), mfc));
                    e.x   = px;
                    e.y   = py;
                    e.eol = (px == W - 1);
                    e.eof = (px == W - 1) && (py == H - 1);
                    q_exp.push_back(e);
                    if (px == W - 1) begin
                        mx = 0;
                        my = (py == H - 1) ? 0 : py + 1;
                    end else begin
                        mx = px + 1;
                        my = py;
                    end
`ifdef DITHER_TEMPORAL_EN
                    if (e.eof) mfc = (mfc + 1) % 4;
`endif
                end
            end
        end
    end

    task automatic send(input logic [DW-1:0] d, input logic sof);
        int guard = 0;
        bit took;
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_sof   = sof;
        forever begin
            @(negedge clk);
            took = bus.s_ready;
            @(posedge clk); #1;
            if (took) break;
            guard++;
            if (guard > 1000) begin
                chk("s_ready_timeout", 32'(took), 32'd1);
                break;
            end
        end
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    // kind 0: constant val, 1: random, 2: ramp x*4
    task automatic send_frame(input int kind, input int val, input int chg_idx,
                              input logic [1:0] chg_mode, input bit with_sof);
        int d;
        for (int i = 0; i < NPIX; i++) begin
            if (i == chg_idx) cfg_mode = chg_mode;
            d = (kind == 0) ? val : (kind == 1) ? int'($urandom_range(0, 255)) : ((i % W) * 4) & 255;
            send(DW'(d), with_sof && (i == 0));
        end
    endtask

    task automatic drain();
        int guard = 0;
        while (q_exp.size() != 0 && guard < 500) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain_empty", 32'(q_exp.size()), 32'd0);
    endtask

    initial begin
        int o0, l0, e0;
        int exp_row0[W] = '{0, 0, 0, 0, 1, 0, 0, 0};
        int const_val[3] = '{0, 255, 128};
        int const_ones[3] = '{0, 64, 32};
        build_bayer();
        bus.s_valid = 1'b0;
        bus.s_data  = '0;
        bus.s_sof   = 1'b0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_m_data", 32'(bus.m_data), 32'd0);
        chk("rst_m_x", 32'(bus.m_x), 32'd0);
        chk("rst_m_y", 32'(bus.m_y), 32'd0);
        chk("rst_m_eol", 32'(bus.m_eol), 32'd0);
        chk("rst_m_eof", 32'(bus.m_eof), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // 8x8 mode, ramp on row 0, two-cycle latency
        cfg_mode = 2'd3;
        cap_row0 = 1'b1;
        send(8'd0, 1'b1);
        chk("lat_one_edge", 32'(bus.m_valid), 32'd0);
        send(8'd4, 1'b0);
        chk("lat_two_edges", 32'(bus.m_valid), 32'd1);
        chk("lat_first_x", 32'(bus.m_x), 32'd0);
        for (int x = 2; x < W; x++) send(DW'(x * 4), 1'b0);
        for (int i = W; i < NPIX; i++) send(DW'($urandom_range(0, 255)), 1'b0);
        drain();
        cap_row0 = 1'b0;
        for (int x = 0; x < W; x++) chk($sformatf("row0_x%0d", x), 32'(row0[x]), 32'(exp_row0[x]));

        // Flat frames: ones per 8x8 tile, one eol per row, a single eof
        for (int v = 0; v < 3; v++) begin
            o0 = n_ones; l0 = n_eol; e0 = n_eof;
            send_frame(0, const_val[v], -1, 2'd0, 1'b0);
            drain();
            chk($sformatf("ones_at_%0d", const_val[v]), 32'(n_ones - o0), 32'(const_ones[v]));
            chk("eol_per_frame", 32'(n_eol - l0), 32'(H));
            chk("eof_per_frame", 32'(n_eof - e0), 32'd1);
        end

        // Random backpressure over every matrix size
        rdy_rand = 1'b1;
        for (int f = 0; f < 4; f++) begin
            cfg_mode = 2'(f);
            send_frame(1, 0, -1, 2'd0, 1'b0);
        end
        drain();
        rdy_rand = 1'b0;

        // Mid-frame size change takes effect at the next frame origin
        cfg_mode = 2'd3;
        send_frame(1, 0, 2 * W + 5, 2'd1, 1'b0);
        send_frame(1, 0, -1, 2'd0, 1'b0);
        drain();

        // 4x4 at level 100: 7 of 16 per tile whatever the frame offset
        cfg_mode = 2'd2;
        o0 = n_ones;
        for (int f = 0; f < 5; f++) send_frame(0, 100, -1, 2'd0, 1'b0);
        drain();
        chk("ones_5frames_100", 32'(n_ones - o0), 32'(5 * 28));

        // s_sof resync part-way through a line
        cfg_mode = 2'd3;
        for (int i = 0; i < 10; i++) send(DW'($urandom_range(0, 255)), 1'b0);
        send_frame(1, 0, -1, 2'd0, 1'b1);
        drain();

        // Asynchronous reset with pixels in flight
        for (int i = 0; i < 20; i++) send(DW'($urandom_range(0, 255)), 1'b0);
        rst = 1'b1;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;
        rdy_rand = 1'b1;
        send_frame(1, 0, -1, 2'd0, 1'b0);
        drain();
        rdy_rand = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
